// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath constants and the U-type result select encoding.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int IMM_W = 20;
    localparam int LOW_W = XLEN - IMM_W;

    typedef enum logic {
        UTYPE_LUI   = 1'b0,
        UTYPE_AUIPC = 1'b1
    } utype_sel_e;

endpackage

// File: rtl/uimm_shift.sv
// Places a U-type immediate in the upper bits of a word, zero-filling the low bits.
module uimm_shift #(
    parameter int IMM_W = 20,
    parameter int LOW_W = 12
) (
    input  logic [IMM_W-1:0]       imm,
    output logic [IMM_W+LOW_W-1:0] imm_ext
);

    // Plain concatenation: the top immediate bit is not treated as a sign.
    assign imm_ext = {imm, {LOW_W{1'b0}}};

endmodule

// File: rtl/extend_20to32.sv
// U-type immediate extender: combinational LUI value for decode and a
// registered LUI/AUIPC result for execute.
module extend_20to32
    import riscv_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int IMM_W_P = IMM_W,
    parameter int LOW_W_P = XLEN_P - IMM_W_P
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IMM_W_P-1:0] Extender,
    output logic [XLEN_P-1:0]  Extendido,
    input  logic               en,
    input  logic               sel_auipc,
    input  logic [XLEN_P-1:0]  pc,
    output logic [XLEN_P-1:0]  result_q,
    output logic               valid_q
);

    logic [XLEN_P-1:0] imm_ext;
    logic [XLEN_P-1:0] next_result;
    logic [XLEN_P-1:0] result_d;
    logic              valid_d;
    utype_sel_e        sel;

    uimm_shift #(
        .IMM_W(IMM_W_P),
        .LOW_W(LOW_W_P)
    ) u_uimm_shift (
        .imm    (Extender),
        .imm_ext(imm_ext)
    );

    assign Extendido = imm_ext;
    assign sel       = utype_sel_e'(sel_auipc);

    // Handshake: valid_q is a one-cycle strobe, high only after an edge that
    // sampled en=1; there is no ready, so a consumer must take it that cycle.
    always_comb begin
        next_result = imm_ext;
        result_d    = result_q;
        valid_d     = 1'b0;
        if (sel == UTYPE_AUIPC) begin
            next_result = pc + imm_ext;  // carry out dropped, wraps mod 2^XLEN
        end
        if (en) begin
            result_d = next_result;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_extend_20to32.sv
// Self-checking bench for extend_20to32: directed and random LUI/AUIPC traffic
// with a queue-based scoreboard for the registered stage.
module tb_extend_20to32;

    logic        clk;
    logic        rst;
    logic [19:0] Extender;
    logic [31:0] Extendido;
    logic        en;
    logic        sel_auipc;
    logic [31:0] pc;
    logic [31:0] result_q;
    logic        valid_q;

    int checks;
    int errors;

    // scoreboard: {valid, result} expected after each driven edge
    logic [32:0] exp_q[$];
    logic [31:0] model_result;

    extend_20to32 dut (
        .clk      (clk),
        .rst      (rst),
        .Extender (Extender),
        .Extendido(Extendido),
        .en       (en),
        .sel_auipc(sel_auipc),
        .pc       (pc),
        .result_q (result_q),
        .valid_q  (valid_q)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish before 200000 ns");
        errors = errors + 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // driver: apply one cycle of inputs, push the model's expectation,
    // then pop and compare just after the edge
    task automatic step(input string tag, input logic e, input logic s,
                        input logic [31:0] p, input logic [19:0] imm);
        logic [31:0] ext;
        logic [31:0] nxt;
        logic [32:0] exp;
        en        = e;
        sel_auipc = s;
        pc        = p;
        Extender  = imm;
        ext = 32'(imm) << 12;
        nxt = s ? (p + ext) : ext;
        if (rst) begin
            model_result = 32'h0;
            exp_q.push_back({1'b0, 32'h0});
        end else if (e) begin
            model_result = nxt;
            exp_q.push_back({1'b1, nxt});
        end else begin
            exp_q.push_back({1'b0, model_result});
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_underflow"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_result"}, result_q, exp[31:0]);
            check({tag, "_valid"}, 32'(valid_q), 32'(exp[32]));
        end
    endtask

    logic [19:0] comb_imm[5] = '{20'd0, 20'd69, 20'd1048574, 20'd250, 20'h0000B};
    logic [31:0] comb_exp[5] = '{32'h0000_0000, 32'h0004_5000, 32'hFFFF_E000,
                                 32'h000F_A000, 32'h0000_B000};

    initial begin
        checks       = 0;
        errors       = 0;
        model_result = 32'h0;
        rst          = 1'b1;
        en           = 1'b0;
        sel_auipc    = 1'b0;
        pc           = 32'h0;
        Extender     = 20'h0;

        #3;
        check("reset_result", result_q, 32'h0);
        check("reset_valid", 32'(valid_q), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // combinational extension, each value held 100 ns
        for (int i = 0; i < 5; i++) begin
            Extender = comb_imm[i];
            #100;
            check($sformatf("ext_table%0d", i), Extendido, comb_exp[i]);
        end
        for (int i = 0; i < 6; i++) begin
            logic [19:0] r;
            r = 20'($urandom_range(0, 20'hFFFFF));
            Extender = r;
            #1;
            check($sformatf("ext_rand%0d", i), Extendido, 32'(r) * 32'd4096);
        end

        step("lui", 1'b1, 1'b0, 32'h0, 20'hABCDE);
        step("hold", 1'b0, 1'b0, 32'h0, 20'h11111);
        step("auipc", 1'b1, 1'b1, 32'h0000_1004, 20'h00010);
        step("auipc_wrap", 1'b1, 1'b1, 32'hFFFF_F000, 20'h00001);
        step("b2b1", 1'b1, 1'b0, 32'h0, 20'h00001);
        step("b2b2", 1'b1, 1'b0, 32'h0, 20'h00002);
        step("b2b3", 1'b1, 1'b0, 32'h0, 20'h00003);

        for (int i = 0; i < 24; i++) begin
            step($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom(), 20'($urandom_range(0, 20'hFFFFF)));
        end

        // asynchronous reset between edges with a nonzero result held
        step("pre_rst", 1'b1, 1'b0, 32'h0, 20'h12345);
        en = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_result", result_q, 32'h0);
        check("async_rst_valid", 32'(valid_q), 32'h0);
        Extender = 20'h55555;
        #1;
        check("ext_in_rst", Extendido, 32'h5555_5000);
        step("in_rst", 1'b1, 1'b1, 32'h1234_0000, 20'h00042);
        rst = 1'b0;
        step("post_rst", 1'b1, 1'b0, 32'h0, 20'h00777);
        step("post_rst_idle", 1'b0, 1'b0, 32'h0, 20'h00000);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/extend_20to32.md
# extend_20to32

Upper-immediate extender for the RISC-V datapath. It places a 20-bit U-type immediate in the upper bits of a 32-bit word and fills the lower 12 bits with zeros, for LUI/AUIPC. The block has two outputs:
- a purely combinational extension for the decode stage;
- a registered result, either the extended immediate or PC plus the extended immediate, for the execute stage.

## Interface
Parameters:
- XLEN, 32, datapath width.
- IMM_W, 20, width of the U-type immediate field.
- LOW_W, XLEN-IMM_W (12), number of zero bits appended below the immediate.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- Extender  input  IMM_W  raw U-type immediate, instruction bits [31:12].
- Extendido  output  XLEN  combinational extension {Extender, LOW_W'b0}.
- en  input  1  load enable for the registered stage.
- sel_auipc  input  1  0 = LUI result, 1 = AUIPC result.
- pc  input  XLEN  program counter of the instruction, used when sel_auipc=1.
- result_q  output  XLEN  registered U-type result.
- valid_q  output  1  result_q holds a result captured on the previous enabled edge.

## Operation
- Extendido = {Extender, 12'h000}.
  - Pure concatenation: no sign or zero extension, no arithmetic.
  - Extender[19] lands on bit 31 unchanged.
  - Valid in every cycle, including while rst is asserted.
- Next result:
  - sel_auipc=0 (LUI): next = Extendido.
  - sel_auipc=1 (AUIPC): next = pc + Extendido, modulo 2^32. Carry out is discarded; no overflow flag.
- Rising clk edge with en=1: result_q <= next, valid_q <= 1.
- Rising clk edge with en=0: result_q holds, valid_q <= 0.
- rst=1: result_q = 0 and valid_q = 0 immediately, independent of clk. Both stay at 0 while rst is high.
- Deassertion of rst takes effect at the next rising edge; the first enabled edge after deassertion loads normally.
- No other state and no state machine.

## Timing
- Extendido: zero-cycle latency, combinational from Extender only.
- result_q/valid_q: one-cycle latency. Inputs sampled at edge N are visible after edge N.
- en high on consecutive edges gives one result per cycle. There is no back-pressure.
- Reset asserted mid-operation discards any pending result; valid_q falls asynchronously.
- Reset values: result_q = 32'h0000_0000, valid_q = 0. Extendido has no reset value (combinational).
- Wrap-around: pc=32'hFFFF_F000 with Extender=20'h00001 gives result_q=32'h0000_0000.

## Structure
- The shared package riscv_pkg holds:
  - the XLEN, IMM_W and LOW_W constants;
  - the U-type select encoding: LUI=1'b0, AUIPC=1'b1.
- One combinational sub-module, uimm_shift, performs the concatenation. It is instantiated once and drives both Extendido and the adder operand.
- The top level holds the mux, the adder and the async-reset registers.

## Test plan
- Extender=20'd0, 20'd69, 20'd1048574, 20'd250, 20'h0000B, each held 100 ns -> Extendido = 32'h0000_0000, 32'h0004_5000, 32'hFFFF_E000, 32'h000F_A000, 32'h0000_B000.
- LUI registered: en=1, sel_auipc=0, Extender=20'hABCDE -> after one edge, result_q=32'hABCD_E000 and valid_q=1. With en=0 on the next edge, result_q holds and valid_q=0.
- AUIPC: pc=32'h0000_1004, Extender=20'h00010, en=1, sel_auipc=1 -> result_q=32'h0001_1004.
- AUIPC wrap: pc=32'hFFFF_F000, Extender=20'h00001 -> result_q=32'h0000_0000, valid_q=1.
- Async reset: with result_q nonzero, assert rst between clock edges -> result_q=0 and valid_q=0 before the next edge, while Extendido still tracks Extender. Deassert rst; the next enabled edge loads normally.
- Back-to-back: en=1 for 3 edges with Extender = 1, 2, 3 (LUI) -> result_q = 32'h0000_1000, 32'h0000_2000, 32'h0000_3000 on successive cycles; valid_q stays at 1.
